// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl
//   Turns a debounced button level into short-press, long-press and
//   double-click events, and steps the LED display-mode index from them.
//   Runs on the button filter's clock, so btn_i needs no synchronizer.
//
// Ports
//   clk_100K  in   system clock (100 kHz)
//   rst       in   asynchronous, active-high reset
//   btn_i     in   debounced button level, 1 = pressed
//   short_o   out  one-cycle pulse, short press classified
//   long_o    out  one-cycle pulse, long press classified
//   double_o  out  one-cycle pulse, double click classified
//   mode_o    out  current LED mode index, 0..MODE_NUM-1
module btn_event_ctrl #(
    parameter int LONG_PRDS    = 50000,
    parameter int DBL_GAP_PRDS = 25000,
    parameter int MODE_NUM     = 4,
    parameter int COUNTWIDTH   = 17,
    parameter int MODEWIDTH    = 2
) (
    input  logic                 clk_100K,
    input  logic                 rst,
    input  logic                 btn_i,
    output logic                 short_o,
    output logic                 long_o,
    output logic                 double_o,
    output logic [MODEWIDTH-1:0] mode_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRESS1 = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_PRESS2 = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [COUNTWIDTH-1:0] LONG_TERM = COUNTWIDTH'(LONG_PRDS - 1);
    localparam logic [COUNTWIDTH-1:0] GAP_TERM  = COUNTWIDTH'(DBL_GAP_PRDS - 1);
    localparam logic [COUNTWIDTH-1:0] CNT_ONE   = COUNTWIDTH'(1);
    localparam logic [MODEWIDTH-1:0]  MODE_LAST = MODEWIDTH'(MODE_NUM - 1);
    localparam logic [MODEWIDTH-1:0]  MODE_ONE  = MODEWIDTH'(1);

    logic [2:0]            state_q, state_d;
    logic [COUNTWIDTH-1:0] cnt_q, cnt_d;
    logic                  short_q, short_d;
    logic                  long_q, long_d;
    logic                  double_q, double_d;
    logic [MODEWIDTH-1:0]  mode_q, mode_d;

    // Classification FSM. The counter is cleared on every state change and
    // only advances while staying in a timed state, so it stops at its
    // terminal value instead of wrapping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_i) begin
                    state_d = S_PRESS1;
                    cnt_d   = '0;
                end
            end
            S_PRESS1: begin
                // A release on the terminal edge wins: it is not a long press.
                if (!btn_i) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_TERM) begin
                    long_d  = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                // A second press on the timeout edge still counts as a double click.
                if (btn_i) begin
                    state_d = S_PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_TERM) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PRESS2: begin
                if (!btn_i) begin
                    double_d = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == LONG_TERM) begin
                    // Second press held too long: report long, drop the double click.
                    long_d  = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                // Wait for release after a long press; nothing is reported.
                if (!btn_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Mode moves on the same edge that raises its pulse.
    always_comb begin
        mode_d = mode_q;
        if (long_d) begin
            mode_d = '0;
        end else if (short_d) begin
            mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_ONE;
        end else if (double_d) begin
            mode_d = (mode_q == '0) ? MODE_LAST : mode_q - MODE_ONE;
        end
    end

    always_ff @(posedge clk_100K or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            mode_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            mode_q   <= mode_d;
        end
    end

    assign short_o  = short_q;
    assign long_o   = long_q;
    assign double_o = double_q;
    assign mode_o   = mode_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl
//   Directed scenarios followed by random press/release trains. The reference
//   model works on edge timestamps: when a press started, when it ended, and
//   whether it is the second press of a pair; events fall out of the elapsed
//   edge counts. Outputs are compared every cycle, 1 time unit after the edge.
module tb_btn_event_ctrl;

    localparam int LONG_PRDS    = 8;
    localparam int DBL_GAP_PRDS = 4;
    localparam int MODE_NUM     = 3;
    localparam int COUNTWIDTH   = 4;
    localparam int MODEWIDTH    = 2;

    logic                 clk_100K = 1'b0;
    logic                 rst      = 1'b1;
    logic                 btn_i    = 1'b0;
    logic                 short_o;
    logic                 long_o;
    logic                 double_o;
    logic [MODEWIDTH-1:0] mode_o;

    btn_event_ctrl #(
        .LONG_PRDS   (LONG_PRDS),
        .DBL_GAP_PRDS(DBL_GAP_PRDS),
        .MODE_NUM    (MODE_NUM),
        .COUNTWIDTH  (COUNTWIDTH),
        .MODEWIDTH   (MODEWIDTH)
    ) dut (
        .clk_100K(clk_100K),
        .rst     (rst),
        .btn_i   (btn_i),
        .short_o (short_o),
        .long_o  (long_o),
        .double_o(double_o),
        .mode_o  (mode_o)
    );

    always #5 clk_100K = ~clk_100K;

    int total = 0;
    int bad   = 0;

    // Reference model: timestamps in edges, -1 = not in that phase.
    int t       = 0;
    int press_t = -1;   // edge on which the current press was first sampled
    int rel_t   = -1;   // edge on which the first press was released
    bit second  = 0;    // current press is the second of a pair
    bit holding = 0;    // long press already reported, waiting for release
    int m_mode  = 0;
    bit e_s, e_l, e_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        press_t = -1; rel_t = -1; second = 0; holding = 0; m_mode = 0;
        e_s = 0; e_l = 0; e_d = 0;
    endtask

    task automatic model_edge(input bit b);
        t++;
        e_s = 0; e_l = 0; e_d = 0;
        if (holding) begin
            if (!b) holding = 0;
        end else if (press_t >= 0) begin
            if (!b) begin
                if (second) e_d = 1;
                else rel_t = t;
                press_t = -1;
            end else if (t - press_t == LONG_PRDS) begin
                e_l = 1; holding = 1; press_t = -1;
            end
        end else if (rel_t >= 0) begin
            if (b) begin
                press_t = t; second = 1; rel_t = -1;
            end else if (t - rel_t == DBL_GAP_PRDS) begin
                e_s = 1; rel_t = -1;
            end
        end else if (b) begin
            press_t = t; second = 0;
        end
        if (e_l) m_mode = 0;
        else if (e_s) m_mode = (m_mode + 1) % MODE_NUM;
        else if (e_d) m_mode = (m_mode + MODE_NUM - 1) % MODE_NUM;
    endtask

    task automatic step(input bit b);
        btn_i = b;
        @(posedge clk_100K);
        model_edge(b);
        #1;
        check("short", short_o, e_s);
        check("long", long_o, e_l);
        check("double", double_o, e_d);
        check("mode", mode_o, m_mode);
    endtask

    task automatic press_release(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_short", short_o, 0);
        check("rst_long", long_o, 0);
        check("rst_double", double_o, 0);
        check("rst_mode", mode_o, 0);
        rst = 1'b0;

        // 1: three short presses, mode 0->1->2->0
        press_release(3, 6);
        check("t1_mode1", mode_o, 1);
        press_release(3, 6);
        press_release(3, 6);
        check("t1_wrap", mode_o, 0);

        // 2: double click from mode 0 wraps to 2
        press_release(2, 2);
        press_release(2, 3);
        check("t2_mode", mode_o, 2);

        // 3: long press from mode 2, held well past the terminal edge
        press_release(20, 3);
        check("t3_mode", mode_o, 0);

        // 4: release on the long-terminal edge -> short; one sample more -> long
        press_release(8, 6);
        check("t4_short_mode", mode_o, 1);
        press_release(9, 3);
        check("t4_long_mode", mode_o, 0);

        // 5: gap of exactly 4 samples -> double; 5 samples -> short, new press
        press_release(2, 4);
        press_release(2, 3);
        check("t5_double_mode", mode_o, 2);
        press_release(2, 5);
        press_release(2, 6);
        check("t5_short_mode", mode_o, 1);

        // 6: async reset in GAP with mode 1
        press_release(2, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("t6_short", short_o, 0);
        check("t6_long", long_o, 0);
        check("t6_double", double_o, 0);
        check("t6_mode", mode_o, 0);
        btn_i = 1'b1;
        @(posedge clk_100K);
        #3 rst = 1'b0;
        repeat (12) step(1'b1);
        check("t6_long_mode", mode_o, 0);
        repeat (3) step(1'b0);

        // random press/release trains around both terminals
        for (int i = 0; i < 80; i++) begin
            press_release($urandom_range(1, 11), $urandom_range(1, 6));
        end
        repeat (6) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
